// File: rtl/axi_llc_arbiter_pkg.sv
// AXI channel types shared by the upstream masters and the LLC port, plus the
// id widening/narrowing helpers used by the two-master LLC arbiter.
package ariane_axi;
    localparam int unsigned IdWidthSlave = 4;
    localparam int unsigned IdWidthLlc   = IdWidthSlave + 1;
    localparam int unsigned AddrWidth    = 64;
    localparam int unsigned DataWidth    = 64;

    typedef logic [IdWidthSlave-1:0] id_slv_t;
    typedef logic [IdWidthLlc-1:0]   id_llc_t;
    typedef logic [AddrWidth-1:0]    addr_t;
    typedef logic [DataWidth-1:0]    data_t;
    typedef logic [DataWidth/8-1:0]  strb_t;

    typedef struct packed {
        id_slv_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region;
        logic [5:0] atop;
    } aw_chan_slv_t;
    typedef struct packed {
        id_llc_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region;
        logic [5:0] atop;
    } aw_chan_llc_t;
    typedef struct packed {
        id_slv_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region;
    } ar_chan_slv_t;
    typedef struct packed {
        id_llc_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region;
    } ar_chan_llc_t;
    typedef struct packed { data_t data; strb_t strb; logic last; } w_chan_t;
    typedef struct packed { id_slv_t id; logic [1:0] resp; } b_chan_slv_t;
    typedef struct packed { id_llc_t id; logic [1:0] resp; } b_chan_llc_t;
    typedef struct packed { id_slv_t id; data_t data; logic [1:0] resp; logic last; } r_chan_slv_t;
    typedef struct packed { id_llc_t id; data_t data; logic [1:0] resp; logic last; } r_chan_llc_t;

    typedef struct packed {
        aw_chan_slv_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        ar_chan_slv_t ar; logic ar_valid; logic r_ready;
    } req_slv_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_slv_t b;
        logic r_valid; r_chan_slv_t r;
    } resp_slv_t;
    typedef struct packed {
        aw_chan_llc_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
        ar_chan_llc_t ar; logic ar_valid; logic r_ready;
    } req_llc_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_llc_t b;
        logic r_valid; r_chan_llc_t r;
    } resp_llc_t;
endpackage

package axi_llc_arbiter_pkg;
    // The id is the leading (MSB) field of every channel struct, so prefixing the
    // source bit widens the id in place and dropping the top bit narrows it.
    function automatic ariane_axi::aw_chan_llc_t widen_aw(input ariane_axi::aw_chan_slv_t aw,
                                                          input logic src);
        return ariane_axi::aw_chan_llc_t'({src, aw});
    endfunction

    function automatic ariane_axi::ar_chan_llc_t widen_ar(input ariane_axi::ar_chan_slv_t ar,
                                                          input logic src);
        return ariane_axi::ar_chan_llc_t'({src, ar});
    endfunction

    function automatic ariane_axi::b_chan_slv_t narrow_b(input ariane_axi::b_chan_llc_t b);
        return ariane_axi::b_chan_slv_t'(b[$bits(ariane_axi::b_chan_slv_t)-1:0]);
    endfunction

    function automatic ariane_axi::r_chan_slv_t narrow_r(input ariane_axi::r_chan_llc_t r);
        return ariane_axi::r_chan_slv_t'(r[$bits(ariane_axi::r_chan_slv_t)-1:0]);
    endfunction
endpackage

// File: rtl/axi_llc_arb_fifo.sv
// Small synchronous FIFO recording which source owns each outstanding W burst.
module axi_llc_arb_fifo #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned DataWidth = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic [DataWidth-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);
    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [DataWidth-1:0] mem_r [Depth];
    logic [PtrWidth-1:0]  wr_ptr_r;
    logic [PtrWidth-1:0]  rd_ptr_r;
    logic [PtrWidth:0]    count_r;
    logic                 push_s;
    logic                 pop_s;

    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;
    assign full     = (count_r == (PtrWidth+1)'(Depth));
    assign empty    = (count_r == (PtrWidth+1)'(0));
    assign pop_data = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PtrWidth'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrWidth'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PtrWidth+1)'(1);
                2'b01:   count_r <= count_r - (PtrWidth+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/axi_llc_arbiter.sv
// Two-master to one-LLC AXI arbiter: round-robin AW/AR grants, W routed in AW
// order through a source FIFO, B/R steered back by the id's source bit.
module axi_llc_arbiter
    import ariane_axi::*;
    import axi_llc_arbiter_pkg::*;
#(
    parameter int unsigned WFifoDepth = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  req_slv_t  [1:0] slv_req_i,
    output resp_slv_t [1:0] slv_resp_o,
    output req_llc_t        mst_req_o,
    input  resp_llc_t       mst_resp_i
);
    logic aw_ptr_r, aw_lock_r, aw_lock_src_r, aw_gnt_s, aw_valid_s, aw_hs_s;
    logic ar_ptr_r, ar_lock_r, ar_lock_src_r, ar_gnt_s, ar_valid_s, ar_hs_s;
    logic fifo_full_s, fifo_empty_s, w_head_s, w_valid_s, w_pop_s;
    logic b_src_s, r_src_s;

    // AW grant: a locked grant holds, otherwise the pointer breaks contention.
    always_comb begin
        aw_gnt_s = 1'b0;
        if (aw_lock_r) begin
            aw_gnt_s = aw_lock_src_r;
        end else if (slv_req_i[0].aw_valid && slv_req_i[1].aw_valid) begin
            aw_gnt_s = aw_ptr_r;
        end else if (slv_req_i[1].aw_valid) begin
            aw_gnt_s = 1'b1;
        end else begin
            aw_gnt_s = 1'b0;
        end
    end

    // AR grant, same policy as AW but with its own pointer and lock.
    always_comb begin
        ar_gnt_s = 1'b0;
        if (ar_lock_r) begin
            ar_gnt_s = ar_lock_src_r;
        end else if (slv_req_i[0].ar_valid && slv_req_i[1].ar_valid) begin
            ar_gnt_s = ar_ptr_r;
        end else if (slv_req_i[1].ar_valid) begin
            ar_gnt_s = 1'b1;
        end else begin
            ar_gnt_s = 1'b0;
        end
    end

    // A full W-order FIFO throttles AW so every accepted burst has a slot.
    assign aw_valid_s = !rst_i && slv_req_i[aw_gnt_s].aw_valid && !fifo_full_s;
    assign aw_hs_s    = aw_valid_s && mst_resp_i.aw_ready;
    assign ar_valid_s = !rst_i && slv_req_i[ar_gnt_s].ar_valid;
    assign ar_hs_s    = ar_valid_s && mst_resp_i.ar_ready;

    assign w_valid_s  = !rst_i && !fifo_empty_s && slv_req_i[w_head_s].w_valid;
    assign w_pop_s    = w_valid_s && mst_resp_i.w_ready && slv_req_i[w_head_s].w.last;

    assign b_src_s    = mst_resp_i.b.id[IdWidthLlc-1];
    assign r_src_s    = mst_resp_i.r.id[IdWidthLlc-1];

    // Round-robin pointers and grant locks for both address channels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_ptr_r      <= 1'b0;
            aw_lock_r     <= 1'b0;
            aw_lock_src_r <= 1'b0;
            ar_ptr_r      <= 1'b0;
            ar_lock_r     <= 1'b0;
            ar_lock_src_r <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_ptr_r  <= ~aw_gnt_s;
                aw_lock_r <= 1'b0;
            end else if (aw_valid_s) begin
                aw_lock_r     <= 1'b1;
                aw_lock_src_r <= aw_gnt_s;
            end
            if (ar_hs_s) begin
                ar_ptr_r  <= ~ar_gnt_s;
                ar_lock_r <= 1'b0;
            end else if (ar_valid_s) begin
                ar_lock_r     <= 1'b1;
                ar_lock_src_r <= ar_gnt_s;
            end
        end
    end

    axi_llc_arb_fifo #(
        .Depth     (WFifoDepth),
        .DataWidth (1)
    ) i_w_order (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (aw_hs_s),
        .push_data (aw_gnt_s),
        .pop       (w_pop_s),
        .pop_data  (w_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Request towards the LLC.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = widen_aw(slv_req_i[aw_gnt_s].aw, aw_gnt_s);
        mst_req_o.aw_valid = aw_valid_s;
        mst_req_o.w        = slv_req_i[w_head_s].w;
        mst_req_o.w_valid  = w_valid_s;
        mst_req_o.ar       = widen_ar(slv_req_i[ar_gnt_s].ar, ar_gnt_s);
        mst_req_o.ar_valid = ar_valid_s;
        mst_req_o.b_ready  = !rst_i && slv_req_i[b_src_s].b_ready;
        mst_req_o.r_ready  = !rst_i && slv_req_i[r_src_s].r_ready;
    end

    // Responses back to each master; handshakes reach only the selected source.
    always_comb begin
        slv_resp_o = '0;
        for (int i = 0; i < 2; i++) begin
            slv_resp_o[i].aw_ready = aw_valid_s && (aw_gnt_s == i[0]) && mst_resp_i.aw_ready;
            slv_resp_o[i].ar_ready = ar_valid_s && (ar_gnt_s == i[0]) && mst_resp_i.ar_ready;
            slv_resp_o[i].w_ready  = !rst_i && !fifo_empty_s && (w_head_s == i[0]) &&
                                     mst_resp_i.w_ready;
            slv_resp_o[i].b        = narrow_b(mst_resp_i.b);
            slv_resp_o[i].b_valid  = !rst_i && mst_resp_i.b_valid && (b_src_s == i[0]);
            slv_resp_o[i].r        = narrow_r(mst_resp_i.r);
            slv_resp_o[i].r_valid  = !rst_i && mst_resp_i.r_valid && (r_src_s == i[0]);
        end
    end
endmodule

// File: tb/tb_axi_llc_arbiter.sv
// Bench for axi_llc_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level arbitration model.
module tb_axi_llc_arbiter;
    import ariane_axi::*;

    localparam int DEPTH = 4;

    logic clk;
    bit   rst;
    req_slv_t  [1:0] slv_req;
    resp_slv_t [1:0] slv_resp;
    req_llc_t        mst_req;
    resp_llc_t       mst_resp;

    // Source-side stimulus
    bit          s_aw_v [2];
    logic [3:0]  s_aw_id [2];
    logic [63:0] s_aw_addr [2];
    logic [7:0]  s_aw_len [2];
    bit          s_w_v [2];
    bit          s_w_last [2];
    logic [63:0] s_w_data [2];
    bit          s_ar_v [2];
    logic [3:0]  s_ar_id [2];
    logic [63:0] s_ar_addr [2];
    bit          s_b_rdy [2];
    bit          s_r_rdy [2];
    // LLC-side stimulus
    bit          l_aw_rdy, l_w_rdy, l_ar_rdy, l_b_v, l_r_v, l_r_last;
    logic [4:0]  l_b_id, l_r_id;
    logic [63:0] l_r_data;

    // Reference model: preferred source per channel, source shown but not yet
    // accepted (-1 if none), and the list of sources owing W bursts.
    int ptr_aw, ptr_ar, pend_aw, pend_ar;
    int wq[$];

    // Observations of DUT behaviour for the directed scenarios
    int obs_aw_id[$];
    int obs_ar_src[$];
    int obs_w_cnt [2];

    int n_tests = 0;
    int n_fail  = 0;

    axi_llc_arbiter #(.WFifoDepth(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        slv_req = '0;
        for (int i = 0; i < 2; i++) begin
            slv_req[i].aw_valid = s_aw_v[i];
            slv_req[i].aw.id    = s_aw_id[i];
            slv_req[i].aw.addr  = s_aw_addr[i];
            slv_req[i].aw.len   = s_aw_len[i];
            slv_req[i].w_valid  = s_w_v[i];
            slv_req[i].w.data   = s_w_data[i];
            slv_req[i].w.last   = s_w_last[i];
            slv_req[i].ar_valid = s_ar_v[i];
            slv_req[i].ar.id    = s_ar_id[i];
            slv_req[i].ar.addr  = s_ar_addr[i];
            slv_req[i].b_ready  = s_b_rdy[i];
            slv_req[i].r_ready  = s_r_rdy[i];
        end
        mst_resp          = '0;
        mst_resp.aw_ready = l_aw_rdy;
        mst_resp.w_ready  = l_w_rdy;
        mst_resp.ar_ready = l_ar_rdy;
        mst_resp.b_valid  = l_b_v;
        mst_resp.b.id     = l_b_id;
        mst_resp.r_valid  = l_r_v;
        mst_resp.r.id     = l_r_id;
        mst_resp.r.data   = l_r_data;
        mst_resp.r.last   = l_r_last;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int pend, input int ptr, input bit v0, input bit v1);
        if (pend >= 0) return pend;
        if (v0 && v1) return ptr;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            s_aw_v[i] = 0; s_aw_id[i] = '0; s_aw_addr[i] = '0; s_aw_len[i] = '0;
            s_w_v[i] = 0; s_w_last[i] = 0; s_w_data[i] = '0;
            s_ar_v[i] = 0; s_ar_id[i] = '0; s_ar_addr[i] = '0;
            s_b_rdy[i] = 0; s_r_rdy[i] = 0;
        end
        l_aw_rdy = 0; l_w_rdy = 0; l_ar_rdy = 0; l_b_v = 0; l_r_v = 0; l_r_last = 0;
        l_b_id = '0; l_r_id = '0; l_r_data = '0;
    endtask

    // One clock cycle: compare outputs against the model, clock, then advance the model.
    task automatic step();
        int  g_aw, g_ar, head, bs, rs;
        bit  awv, arv, wv, aw_hs, ar_hs, w_pop;
        #3;
        if (rst) begin
            check_val("rst_aw_valid", mst_req.aw_valid, 1'b0);
            check_val("rst_w_valid", mst_req.w_valid, 1'b0);
            check_val("rst_ar_valid", mst_req.ar_valid, 1'b0);
            check_val("rst_b_ready", mst_req.b_ready, 1'b0);
            check_val("rst_r_ready", mst_req.r_ready, 1'b0);
            for (int i = 0; i < 2; i++) begin
                check_val("rst_s_aw_ready", slv_resp[i].aw_ready, 1'b0);
                check_val("rst_s_w_ready", slv_resp[i].w_ready, 1'b0);
                check_val("rst_s_ar_ready", slv_resp[i].ar_ready, 1'b0);
                check_val("rst_s_b_valid", slv_resp[i].b_valid, 1'b0);
                check_val("rst_s_r_valid", slv_resp[i].r_valid, 1'b0);
            end
            @(posedge clk);
            #1;
            ptr_aw = 0; ptr_ar = 0; pend_aw = -1; pend_ar = -1;
            wq.delete();
            return;
        end
        g_aw = pick(pend_aw, ptr_aw, s_aw_v[0], s_aw_v[1]);
        awv  = (g_aw >= 0) && (wq.size() < DEPTH);
        check_val("aw_valid", mst_req.aw_valid, awv);
        if (awv) begin
            check_val("aw_id", mst_req.aw.id, {g_aw[0], s_aw_id[g_aw]});
            check_val("aw_addr", mst_req.aw.addr, s_aw_addr[g_aw]);
            check_val("aw_len", mst_req.aw.len, s_aw_len[g_aw]);
        end
        g_ar = pick(pend_ar, ptr_ar, s_ar_v[0], s_ar_v[1]);
        arv  = (g_ar >= 0);
        check_val("ar_valid", mst_req.ar_valid, arv);
        if (arv) begin
            check_val("ar_id", mst_req.ar.id, {g_ar[0], s_ar_id[g_ar]});
            check_val("ar_addr", mst_req.ar.addr, s_ar_addr[g_ar]);
        end
        head = (wq.size() > 0) ? wq[0] : -1;
        wv   = (head >= 0) && s_w_v[head];
        check_val("w_valid", mst_req.w_valid, wv);
        if (wv) begin
            check_val("w_data", mst_req.w.data, s_w_data[head]);
            check_val("w_last", mst_req.w.last, s_w_last[head]);
        end
        for (int i = 0; i < 2; i++) begin
            check_val("s_aw_ready", slv_resp[i].aw_ready, awv && g_aw == i && l_aw_rdy);
            check_val("s_ar_ready", slv_resp[i].ar_ready, arv && g_ar == i && l_ar_rdy);
            check_val("s_w_ready", slv_resp[i].w_ready, head == i && l_w_rdy);
        end
        bs = int'(l_b_id[4]);
        rs = int'(l_r_id[4]);
        for (int i = 0; i < 2; i++) begin
            check_val("s_b_valid", slv_resp[i].b_valid, l_b_v && bs == i);
            check_val("s_r_valid", slv_resp[i].r_valid, l_r_v && rs == i);
        end
        if (l_b_v) check_val("s_b_id", slv_resp[bs].b.id, l_b_id[3:0]);
        if (l_r_v) begin
            check_val("s_r_id", slv_resp[rs].r.id, l_r_id[3:0]);
            check_val("s_r_data", slv_resp[rs].r.data, l_r_data);
            check_val("s_r_last", slv_resp[rs].r.last, l_r_last);
        end
        check_val("b_ready", mst_req.b_ready, s_b_rdy[bs]);
        check_val("r_ready", mst_req.r_ready, s_r_rdy[rs]);

        if (mst_req.aw_valid && l_aw_rdy) obs_aw_id.push_back(int'(mst_req.aw.id));
        for (int i = 0; i < 2; i++) begin
            if (slv_resp[i].ar_ready) obs_ar_src.push_back(i);
            if (slv_resp[i].w_ready && s_w_v[i]) obs_w_cnt[i]++;
        end

        aw_hs = awv && l_aw_rdy;
        ar_hs = arv && l_ar_rdy;
        w_pop = wv && l_w_rdy && s_w_last[head];
        @(posedge clk);
        #1;
        if (aw_hs) begin
            ptr_aw = 1 - g_aw; pend_aw = -1; s_aw_v[g_aw] = 0;
        end else if (awv) begin
            pend_aw = g_aw;
        end
        if (ar_hs) begin
            ptr_ar = 1 - g_ar; pend_ar = -1; s_ar_v[g_ar] = 0;
        end else if (arv) begin
            pend_ar = g_ar;
        end
        if (w_pop) void'(wq.pop_front());
        if (aw_hs) wq.push_back(g_aw);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
        obs_aw_id.delete();
        obs_ar_src.delete();
        obs_w_cnt[0] = 0;
        obs_w_cnt[1] = 0;
    endtask

    initial begin
        int ones;
        rst = 1;
        clear_inputs();
        step();
        do_reset();

        // Simultaneous AW after reset: source 0 first, then source 1, pointer back to 0.
        s_aw_v[0] = 1; s_aw_id[0] = 4'h3;
        s_aw_v[1] = 1; s_aw_id[1] = 4'h5;
        l_aw_rdy = 1;
        step();
        step();
        s_aw_v[0] = 1; s_aw_v[1] = 1;
        step();
        check_val("r027_count", obs_aw_id.size(), 3);
        if (obs_aw_id.size() >= 3) begin
            check_val("r027_first_id", obs_aw_id[0], 5'h03);
            check_val("r027_second_id", obs_aw_id[1], 5'h15);
            check_val("r027_ptr_zero", obs_aw_id[2], 5'h03);
        end

        // Source-1 burst of 4 beats while source 0 offers W without an AW.
        do_reset();
        l_aw_rdy = 1; l_w_rdy = 1;
        s_aw_v[1] = 1; s_aw_id[1] = 4'h1; s_aw_len[1] = 8'd3;
        s_w_v[0] = 1; s_w_data[0] = 64'hdead;
        s_w_v[1] = 1; s_w_data[1] = 64'h100;
        step();
        check_val("r028_no_bypass", obs_w_cnt[1], 0);
        for (int k = 0; k < 4; k++) begin
            s_w_data[1] = 64'h100 + 64'(k);
            s_w_last[1] = (k == 3);
            step();
        end
        s_w_v[1] = 0;
        check_val("r028_w_idle", mst_req.w_valid, 1'b0);
        check_val("r028_src1_beats", obs_w_cnt[1], 4);
        check_val("r028_src0_beats", obs_w_cnt[0], 0);

        // Four AWs fill the W-order FIFO; the fifth waits for a W last.
        do_reset();
        l_aw_rdy = 1; l_w_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            s_aw_v[0] = 1; s_aw_id[0] = 4'(k);
            step();
        end
        s_aw_v[0] = 1; s_aw_id[0] = 4'h9;
        for (int k = 0; k < 3; k++) step();
        check_val("r029_held_count", obs_aw_id.size(), 4);
        check_val("r029_held_valid", mst_req.aw_valid, 1'b0);
        s_w_v[0] = 1; s_w_last[0] = 1;
        step();
        s_w_v[0] = 0;
        check_val("r029_release_valid", mst_req.aw_valid, 1'b1);
        step();
        check_val("r029_fifth_count", obs_aw_id.size(), 5);

        // R and B returned in the same cycle to different sources.
        do_reset();
        s_r_rdy[0] = 1; s_r_rdy[1] = 1; s_b_rdy[0] = 1; s_b_rdy[1] = 1;
        l_r_v = 1; l_r_id = 5'h12; l_r_last = 0; l_r_data = 64'haaaa;
        l_b_v = 1; l_b_id = 5'h07;
        #1;
        check_val("r030_r1_valid", slv_resp[1].r_valid, 1'b1);
        check_val("r030_r0_valid", slv_resp[0].r_valid, 1'b0);
        check_val("r030_r_id", slv_resp[1].r.id, 4'h2);
        check_val("r030_beat1_last", slv_resp[1].r.last, 1'b0);
        check_val("r030_b0_valid", slv_resp[0].b_valid, 1'b1);
        check_val("r030_b1_valid", slv_resp[1].b_valid, 1'b0);
        check_val("r030_b_id", slv_resp[0].b.id, 4'h7);
        step();
        l_b_v = 0; l_r_last = 1; l_r_data = 64'hbbbb;
        #1;
        check_val("r030_beat2_valid", slv_resp[1].r_valid, 1'b1);
        check_val("r030_beat2_last", slv_resp[1].r.last, 1'b1);
        step();

        // Reset in the middle of a W burst with two bursts outstanding.
        do_reset();
        l_aw_rdy = 1;
        s_aw_v[0] = 1; step();
        s_aw_v[1] = 1; step();
        l_aw_rdy = 0; l_w_rdy = 1;
        s_w_v[0] = 1; s_w_last[0] = 0;
        step();
        s_w_v[1] = 1; s_aw_v[0] = 1; s_aw_v[1] = 1; s_ar_v[0] = 1; s_ar_v[1] = 1;
        rst = 1;
        step();
        rst = 0;
        #1;
        check_val("r031_fifo_empty", mst_req.w_valid, 1'b0);
        check_val("r031_aw_ptr", mst_req.aw.id[4], 1'b0);
        check_val("r031_ar_ptr", mst_req.ar.id[4], 1'b0);
        step();

        // Continuous AR from both sources alternates grants.
        do_reset();
        l_ar_rdy = 1;
        for (int k = 0; k < 8; k++) begin
            s_ar_v[0] = 1; s_ar_v[1] = 1;
            s_ar_id[0] = 4'(k); s_ar_id[1] = 4'(k + 8);
            step();
        end
        check_val("r032_count", obs_ar_src.size(), 8);
        ones = 0;
        for (int k = 0; k < obs_ar_src.size(); k++) begin
            check_val("r032_order", obs_ar_src[k], k % 2);
            ones += obs_ar_src[k];
        end
        check_val("r032_src1_grants", ones, 4);

        // Randomized traffic; sources hold AW/AR valid until accepted.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!s_aw_v[i] && ($urandom % 3 == 0)) begin
                    s_aw_v[i] = 1; s_aw_id[i] = 4'($urandom);
                    s_aw_addr[i] = {$urandom, $urandom}; s_aw_len[i] = 8'($urandom);
                end
                if (!s_ar_v[i] && ($urandom % 3 == 0)) begin
                    s_ar_v[i] = 1; s_ar_id[i] = 4'($urandom);
                    s_ar_addr[i] = {$urandom, $urandom};
                end
                s_w_v[i] = 1'($urandom % 2);
                s_w_last[i] = ($urandom % 3 == 0);
                s_w_data[i] = {$urandom, $urandom};
                s_b_rdy[i] = 1'($urandom % 2);
                s_r_rdy[i] = 1'($urandom % 2);
            end
            l_aw_rdy = ($urandom % 4 != 0);
            l_w_rdy  = ($urandom % 4 != 0);
            l_ar_rdy = ($urandom % 4 != 0);
            l_b_v = 1'($urandom % 2); l_b_id = 5'($urandom);
            l_r_v = 1'($urandom % 2); l_r_id = 5'($urandom);
            l_r_last = 1'($urandom % 2); l_r_data = {$urandom, $urandom};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
